// File: rtl/inst_rom.sv
// Instruction memory with a combinational fetch port and a program loader.
// The core is held stopped (out_core_run=0) until a load completes.
module inst_rom #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           in_rom_address,
  input  logic                  in_rom_enable,
  output logic [31:0]           out_rom_data,
  input  logic                  in_load_start,
  input  logic [ADDR_WIDTH:0]   in_load_count,
  input  logic                  in_load_valid,
  input  logic [31:0]           in_load_data,
  output logic                  out_load_ready,
  output logic                  out_load_done,
  output logic                  out_load_error,
  output logic                  out_core_run,
  output logic                  out_fetch_error
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_W   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH:0]   ptr_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic                  ready_q;
  logic                  run_q;
  logic                  done_q;
  logic                  err_q;
  logic                  ferr_q;
  logic [31:0]           mem_q [DEPTH];

  logic                  count_ok;
  logic                  accept;
  logic                  last_word;
  logic                  addr_good;
  logic                  fetch_bad;
  logic [ADDR_WIDTH-1:0] word_addr;

  // Handshake: a word moves on any rising edge where in_load_valid && out_load_ready;
  // ready is high for exactly the cycles spent in LOAD, valid may drop at any time.
  assign count_ok  = (in_load_count != '0) && (in_load_count <= DEPTH_W);
  assign accept    = ready_q && in_load_valid;
  assign last_word = (ptr_q == (cnt_q - ONE_W));

  assign word_addr = in_rom_address[ADDR_WIDTH+1:2];
  assign addr_good = (in_rom_address[1:0] == 2'b00) &&
                     (in_rom_address[31:ADDR_WIDTH+2] == '0);
  assign fetch_bad = in_rom_enable && run_q && !addr_good;

  // Zero decodes as a NOP, so a stopped core or a bad fetch sees harmless words.
  assign out_rom_data = (in_rom_enable && run_q && addr_good) ? mem_q[word_addr] : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (fetch_bad) ferr_q <= 1'b1;
      case (state_q)
        EMPTY, RUN: begin
          if (in_load_start && count_ok) begin
            state_q <= LOAD;
            ptr_q   <= '0;
            cnt_q   <= in_load_count;
            ferr_q  <= 1'b0;
            ready_q <= 1'b1;
            run_q   <= 1'b0;
          end else if (in_load_start) begin
            err_q <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            ptr_q <= ptr_q + ONE_W;
            if (last_word) begin
              state_q <= RUN;
              ready_q <= 1'b0;
              run_q   <= 1'b1;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  // Contents survive reset; only accepted load words write.
  always_ff @(posedge clk) begin
    if (accept) mem_q[ptr_q[ADDR_WIDTH-1:0]] <= in_load_data;
  end

  assign out_load_ready  = ready_q;
  assign out_load_done   = done_q;
  assign out_load_error  = err_q;
  assign out_core_run    = run_q;
  assign out_fetch_error = ferr_q;

endmodule

// File: tb/tb_inst_rom.sv
// Directed bench for inst_rom with ADDR_WIDTH=4 (16 words).
module tb_inst_rom;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   in_rom_address = '0;
  logic          in_rom_enable = 1'b0;
  logic [31:0]   out_rom_data;
  logic          in_load_start = 1'b0;
  logic [AW:0]   in_load_count = '0;
  logic          in_load_valid = 1'b0;
  logic [31:0]   in_load_data = '0;
  logic          out_load_ready;
  logic          out_load_done;
  logic          out_load_error;
  logic          out_core_run;
  logic          out_fetch_error;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_mem [16];

  inst_rom #(.ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_rom_address (in_rom_address),
    .in_rom_enable  (in_rom_enable),
    .out_rom_data   (out_rom_data),
    .in_load_start  (in_load_start),
    .in_load_count  (in_load_count),
    .in_load_valid  (in_load_valid),
    .in_load_data   (in_load_data),
    .out_load_ready (out_load_ready),
    .out_load_done  (out_load_done),
    .out_load_error (out_load_error),
    .out_core_run   (out_core_run),
    .out_fetch_error(out_fetch_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a);
    in_rom_enable  = 1'b1;
    in_rom_address = a;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    fetch(32'h0);
    repeat (2) tick();
    checks++; if (out_rom_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", out_rom_data); end
    checks++; if ({out_core_run, out_load_ready, out_load_done, out_load_error, out_fetch_error} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got=%b exp=00000",
        {out_core_run, out_load_ready, out_load_done, out_load_error, out_fetch_error}); end
    rst_n = 1'b1;
    tick();
    checks++; if (out_rom_data !== 32'h0) begin errors++; $display("FAIL post_reset_data got=%h exp=0", out_rom_data); end
    checks++; if ({out_core_run, out_load_ready} !== 2'b00) begin
      errors++; $display("FAIL post_reset_run_ready got=%b exp=00", {out_core_run, out_load_ready}); end
  endtask

  task automatic test_bad_start;
    logic [AW:0] bad_cnt [2];
    bad_cnt[0] = 5'd0;
    bad_cnt[1] = 5'd17;
    for (int k = 0; k < 2; k++) begin
      in_load_start = 1'b1;
      in_load_count = bad_cnt[k];
      tick();
      in_load_start = 1'b0;
      checks++; if (out_load_error !== 1'b1) begin errors++; $display("FAIL bad_start_err cnt=%0d got=%b exp=1", bad_cnt[k], out_load_error); end
      checks++; if ({out_core_run, out_load_ready} !== 2'b00) begin
        errors++; $display("FAIL bad_start_state cnt=%0d got=%b exp=00", bad_cnt[k], {out_core_run, out_load_ready}); end
      tick();
      checks++; if (out_load_error !== 1'b0) begin errors++; $display("FAIL bad_start_pulse cnt=%0d got=%b exp=0", bad_cnt[k], out_load_error); end
      checks++; if (out_load_ready !== 1'b0) begin errors++; $display("FAIL bad_start_stay cnt=%0d ready=%b exp=0", bad_cnt[k], out_load_ready); end
    end
  endtask

  task automatic test_full_load;
    in_load_start = 1'b1;
    in_load_count = 5'd16;
    tick();
    in_load_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++; if ({out_load_ready, out_core_run, out_load_done} !== 3'b100) begin
        errors++; $display("FAIL full_load_busy i=%0d got=%b exp=100", i, {out_load_ready, out_core_run, out_load_done}); end
      in_load_valid = 1'b1;
      in_load_data  = 32'hA500_0000 | 32'(i);
      exp_mem[i]    = 32'hA500_0000 | 32'(i);
      tick();
    end
    in_load_valid = 1'b0;
    checks++; if ({out_load_done, out_core_run, out_load_ready} !== 3'b110) begin
      errors++; $display("FAIL full_load_done got=%b exp=110", {out_load_done, out_core_run, out_load_ready}); end
    tick();
    checks++; if ({out_load_done, out_core_run} !== 2'b01) begin
      errors++; $display("FAIL full_load_done_pulse got=%b exp=01", {out_load_done, out_core_run}); end
    for (int i = 0; i < 16; i++) begin
      fetch(32'(i * 4));
      checks++; if (out_rom_data !== exp_mem[i]) begin errors++; $display("FAIL full_load_fetch i=%0d got=%h exp=%h", i, out_rom_data, exp_mem[i]); end
    end
  endtask

  task automatic test_load3;
    logic [31:0] w [3];
    w[0] = 32'h3401_0001;
    w[1] = 32'h3402_0002;
    w[2] = 32'h3403_0003;
    in_load_start = 1'b1;
    in_load_count = 5'd3;
    tick();
    in_load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({out_load_ready, out_core_run} !== 2'b10) begin
        errors++; $display("FAIL load3_ready i=%0d got=%b exp=10", i, {out_load_ready, out_core_run}); end
      in_load_valid = 1'b1;
      in_load_data  = w[i];
      exp_mem[i]    = w[i];
      tick();
    end
    in_load_valid = 1'b0;
    checks++; if ({out_load_done, out_core_run, out_load_ready} !== 3'b110) begin
      errors++; $display("FAIL load3_done got=%b exp=110", {out_load_done, out_core_run, out_load_ready}); end
    tick();
    for (int i = 0; i < 4; i++) begin
      fetch(32'(i * 4));
      checks++; if (out_rom_data !== exp_mem[i]) begin errors++; $display("FAIL load3_fetch addr=%h got=%h exp=%h", i * 4, out_rom_data, exp_mem[i]); end
    end
  endtask

  task automatic test_load_gaps;
    logic [3:0] pat;
    int idx;
    pat = 4'b1001;
    idx = 0;
    in_load_start = 1'b1;
    in_load_count = 5'd2;
    tick();
    in_load_start = 1'b0;
    in_load_count = 5'd5;
    for (int k = 0; k < 4; k++) begin
      checks++; if ({out_load_ready, out_load_done, out_core_run} !== 3'b100) begin
        errors++; $display("FAIL gaps_busy k=%0d got=%b exp=100", k, {out_load_ready, out_load_done, out_core_run}); end
      in_load_valid = pat[3 - k];
      in_load_data  = 32'h1111_0000 | 32'(k);
      if (pat[3 - k]) begin
        exp_mem[idx] = 32'h1111_0000 | 32'(k);
        idx++;
      end
      tick();
    end
    in_load_valid = 1'b0;
    checks++; if ({out_load_done, out_core_run} !== 2'b11) begin
      errors++; $display("FAIL gaps_done got=%b exp=11", {out_load_done, out_core_run}); end
    tick();
    checks++; if (out_load_done !== 1'b0) begin errors++; $display("FAIL gaps_done_pulse got=%b exp=0", out_load_done); end
    in_load_valid = 1'b1;
    in_load_data  = 32'hDEAD_BEEF;
    repeat (2) tick();
    in_load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fetch(32'(i * 4));
      checks++; if (out_rom_data !== exp_mem[i]) begin errors++; $display("FAIL gaps_fetch addr=%h got=%h exp=%h", i * 4, out_rom_data, exp_mem[i]); end
    end
  endtask

  task automatic test_fetch_error;
    fetch(32'h0000_0042);
    checks++; if (out_rom_data !== 32'h0) begin errors++; $display("FAIL ferr_misaligned_data got=%h exp=0", out_rom_data); end
    checks++; if (out_fetch_error !== 1'b0) begin errors++; $display("FAIL ferr_before_edge got=%b exp=0", out_fetch_error); end
    tick();
    checks++; if (out_fetch_error !== 1'b1) begin errors++; $display("FAIL ferr_set got=%b exp=1", out_fetch_error); end
    fetch(32'h0000_0040);
    checks++; if (out_rom_data !== 32'h0) begin errors++; $display("FAIL ferr_range_data got=%h exp=0", out_rom_data); end
    tick();
    in_rom_enable = 1'b0;
    in_rom_address = 32'h4;
    #1;
    checks++; if (out_rom_data !== 32'h0) begin errors++; $display("FAIL fetch_disabled got=%h exp=0", out_rom_data); end
    fetch(32'h0);
    checks++; if (out_rom_data !== exp_mem[0]) begin errors++; $display("FAIL ferr_good_fetch got=%h exp=%h", out_rom_data, exp_mem[0]); end
    tick();
    checks++; if (out_fetch_error !== 1'b1) begin errors++; $display("FAIL ferr_sticky got=%b exp=1", out_fetch_error); end
    in_load_start = 1'b1;
    in_load_count = 5'd1;
    tick();
    in_load_start = 1'b0;
    checks++; if ({out_fetch_error, out_core_run, out_load_ready} !== 3'b001) begin
      errors++; $display("FAIL reload_start got=%b exp=001", {out_fetch_error, out_core_run, out_load_ready}); end
    checks++; if (out_rom_data !== 32'h0) begin errors++; $display("FAIL reload_data_nop got=%h exp=0", out_rom_data); end
    in_load_valid = 1'b1;
    in_load_data  = 32'h2222_0000;
    exp_mem[0]    = 32'h2222_0000;
    in_load_start = 1'b1;
    in_load_count = 5'd3;
    tick();
    in_load_valid = 1'b0;
    in_load_start = 1'b0;
    checks++; if ({out_load_done, out_core_run, out_load_ready, out_load_error} !== 4'b1100) begin
      errors++; $display("FAIL start_on_last got=%b exp=1100", {out_load_done, out_core_run, out_load_ready, out_load_error}); end
    tick();
    checks++; if ({out_load_done, out_core_run, out_load_ready} !== 3'b010) begin
      errors++; $display("FAIL start_on_last_run got=%b exp=010", {out_load_done, out_core_run, out_load_ready}); end
    fetch(32'h0);
    checks++; if (out_rom_data !== exp_mem[0]) begin errors++; $display("FAIL reload_fetch0 got=%h exp=%h", out_rom_data, exp_mem[0]); end
    fetch(32'h4);
    checks++; if (out_rom_data !== exp_mem[1]) begin errors++; $display("FAIL reload_fetch1 got=%h exp=%h", out_rom_data, exp_mem[1]); end
  endtask

  task automatic test_reset_mid_load;
    fetch(32'h0);
    in_load_start = 1'b1;
    in_load_count = 5'd4;
    tick();
    in_load_start = 1'b0;
    in_load_valid = 1'b1;
    in_load_data  = 32'h3333_0000;
    exp_mem[0]    = 32'h3333_0000;
    tick();
    in_load_data  = 32'h3333_0001;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({out_core_run, out_load_ready, out_load_done, out_load_error, out_fetch_error} !== 5'b0) begin
      errors++; $display("FAIL mid_reset_flags got=%b exp=00000",
        {out_core_run, out_load_ready, out_load_done, out_load_error, out_fetch_error}); end
    checks++; if (out_rom_data !== 32'h0) begin errors++; $display("FAIL mid_reset_data got=%h exp=0", out_rom_data); end
    tick();
    in_load_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++; if ({out_core_run, out_load_ready} !== 2'b00) begin
      errors++; $display("FAIL mid_reset_release got=%b exp=00", {out_core_run, out_load_ready}); end
    in_load_start = 1'b1;
    in_load_count = 5'd1;
    tick();
    in_load_start = 1'b0;
    in_load_valid = 1'b1;
    in_load_data  = 32'h4444_0000;
    exp_mem[0]    = 32'h4444_0000;
    tick();
    in_load_valid = 1'b0;
    fetch(32'h4);
    checks++; if (out_rom_data !== exp_mem[1]) begin errors++; $display("FAIL mid_reset_word1 got=%h exp=%h", out_rom_data, exp_mem[1]); end
    fetch(32'h0);
    checks++; if (out_rom_data !== exp_mem[0]) begin errors++; $display("FAIL mid_reset_word0 got=%h exp=%h", out_rom_data, exp_mem[0]); end
  endtask

  initial begin
    test_reset();
    test_bad_start();
    test_full_load();
    test_load3();
    test_load_gaps();
    test_fetch_error();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
